bus_command_controller: RTL and testbench

BUS_COMMAND_CONTROLLER -- requirements
Module: bus_command_controller

---
 rtl/bus_command_controller_pkg.sv | 54 +++++
 rtl/bus_command_controller_if.sv | 29 ++
 rtl/bus_command_controller_decoder.sv | 17 +
 rtl/bus_command_controller.sv | 93 +++++++++
 tb/tb_bus_command_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bus_command_controller_pkg.sv
// Shared types for the bus command controller: CPU status codes, sequencer
// states and the mapping from a latched cycle type to its command strobe.
package bus_command_controller_pkg;

  typedef enum logic [2:0] {
    STATUS_INTA       = 3'b000,
    STATUS_IO_READ    = 3'b001,
    STATUS_IO_WRITE   = 3'b010,
    STATUS_HALT       = 3'b011,
    STATUS_CODE_FETCH = 3'b100,
    STATUS_MEM_READ   = 3'b101,
    STATUS_MEM_WRITE  = 3'b110,
    STATUS_PASSIVE    = 3'b111
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  // Strobe vector order: {memory_read_n, memory_write_n, io_read_n, io_write_n, interrupt_acknowledge_n}
  localparam logic [4:0] STROBE_NONE      = 5'b11111;
  localparam logic [4:0] STROBE_MEM_READ  = 5'b01111;
  localparam logic [4:0] STROBE_MEM_WRITE = 5'b10111;
  localparam logic [4:0] STROBE_IO_READ   = 5'b11011;
  localparam logic [4:0] STROBE_IO_WRITE  = 5'b11101;
  localparam logic [4:0] STROBE_INTA      = 5'b11110;

  function automatic logic [4:0] strobe_for(status_e cycle_type);
    case (cycle_type)
      STATUS_INTA:       return STROBE_INTA;
      STATUS_IO_READ:    return STROBE_IO_READ;
      STATUS_IO_WRITE:   return STROBE_IO_WRITE;
      STATUS_CODE_FETCH: return STROBE_MEM_READ;
      STATUS_MEM_READ:   return STROBE_MEM_READ;
      STATUS_MEM_WRITE:  return STROBE_MEM_WRITE;
      default:           return STROBE_NONE;
    endcase
  endfunction

  // Only writes drive the data buffers outward; reads, fetches and INTA receive.
  function automatic logic is_transmit(status_e cycle_type);
    case (cycle_type)
      STATUS_INTA, STATUS_IO_READ, STATUS_CODE_FETCH, STATUS_MEM_READ: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_command_controller_if.sv
// CPU-status inputs and command/buffer-control outputs of the bus command controller.
interface bus_command_controller_if;
  logic [2:0] processor_status;
  logic       processor_ready;
  logic       address_enable;
  logic       address_latch_enable;
  logic       data_transmit_receive_n;
  logic       data_enable;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       io_read_n;
  logic       io_write_n;
  logic       interrupt_acknowledge_n;
  logic       bus_cycle_active;

  modport master (
    input  processor_status, processor_ready, address_enable,
    output address_latch_enable, data_transmit_receive_n, data_enable,
           memory_read_n, memory_write_n, io_read_n, io_write_n,
           interrupt_acknowledge_n, bus_cycle_active
  );

  modport slave (
    output processor_status, processor_ready, address_enable,
    input  address_latch_enable, data_transmit_receive_n, data_enable,
           memory_read_n, memory_write_n, io_read_n, io_write_n,
           interrupt_acknowledge_n, bus_cycle_active
  );
endinterface

// File: rtl/bus_command_controller_decoder.sv
// Purely combinational classification of the raw CPU status lines.
module bus_status_decoder
  import bus_command_controller_pkg::*;
(
  input  logic [2:0] status,
  output status_e    cycle_type,
  output logic       is_passive,
  output logic       is_halt,
  output logic       direction
);

  assign cycle_type = status_e'(status);
  assign is_passive = (cycle_type == STATUS_PASSIVE);
  assign is_halt    = (cycle_type == STATUS_HALT);
  assign direction  = is_transmit(cycle_type);

endmodule

// File: rtl/bus_command_controller.sv
// Bus command controller: sequences T1..T4 (plus wait states) from CPU status
// and produces registered command strobes, ALE and data-buffer controls.
module bus_command_controller
  import bus_command_controller_pkg::*;
(
  input logic clock,
  input logic reset,
  bus_command_controller_if.master bus
);

  state_e     state, next_state;
  status_e    cycle_type, next_cycle_type;
  logic       cycle_direction, next_direction;
  status_e    decoded_type;
  logic       decoded_passive, decoded_halt, decoded_direction;
  logic       strobe_window, data_window, active_window;
  logic [4:0] strobe_q;
  logic       ale_q, data_enable_q, dtr_q, active_q;

  bus_status_decoder u_decoder (
    .status     (bus.processor_status),
    .cycle_type (decoded_type),
    .is_passive (decoded_passive),
    .is_halt    (decoded_halt),
    .direction  (decoded_direction)
  );

  // T4 samples status exactly like IDLE so back-to-back cycles need no idle clock.
  always_comb begin
    next_state      = state;
    next_cycle_type = cycle_type;
    next_direction  = cycle_direction;
    case (state)
      ST_IDLE, ST_T4: begin
        if (decoded_halt) begin
          next_state = ST_HALT;
        end else if (decoded_passive) begin
          next_state = ST_IDLE;
        end else begin
          next_state      = ST_T1;
          next_cycle_type = decoded_type;
          next_direction  = decoded_direction;
        end
      end
      ST_T1:   next_state = ST_T2;
      ST_T2:   next_state = ST_T3;
      ST_T3:   next_state = bus.processor_ready ? ST_T4 : ST_TW;
      ST_TW:   next_state = bus.processor_ready ? ST_T4 : ST_TW;
      ST_HALT: next_state = decoded_passive ? ST_IDLE : ST_HALT;
      default: next_state = ST_IDLE;
    endcase

    strobe_window = (next_state == ST_T2) || (next_state == ST_T3) || (next_state == ST_TW);
    data_window   = strobe_window || (next_state == ST_T4);
    active_window = data_window || (next_state == ST_T1);
  end

  // Outputs are registered from the next state so every strobe edge is glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cycle_type      <= STATUS_PASSIVE;
      cycle_direction <= 1'b1;
      strobe_q        <= STROBE_NONE;
      ale_q           <= 1'b0;
      data_enable_q   <= 1'b0;
      dtr_q           <= 1'b1;
      active_q        <= 1'b0;
    end else begin
      state           <= next_state;
      cycle_type      <= next_cycle_type;
      cycle_direction <= next_direction;
      strobe_q        <= strobe_window ? strobe_for(next_cycle_type) : STROBE_NONE;
      ale_q           <= (next_state == ST_T1);
      data_enable_q   <= data_window;
      dtr_q           <= active_window ? next_direction : 1'b1;
      active_q        <= active_window;
    end
  end

  assign bus.address_latch_enable    = ale_q;
  assign bus.data_transmit_receive_n = dtr_q;
  assign bus.data_enable             = data_enable_q;
  assign bus.bus_cycle_active        = active_q;

  // DMA ownership masks the strobes without disturbing the sequencer.
  assign bus.memory_read_n           = strobe_q[4] | bus.address_enable;
  assign bus.memory_write_n          = strobe_q[3] | bus.address_enable;
  assign bus.io_read_n               = strobe_q[2] | bus.address_enable;
  assign bus.io_write_n              = strobe_q[1] | bus.address_enable;
  assign bus.interrupt_acknowledge_n = strobe_q[0] | bus.address_enable;

endmodule

// File: tb/tb_bus_command_controller.sv
// Directed scoreboard bench for bus_command_controller: expected per-clock
// output vectors are queued as each bus cycle is driven and popped after each edge.
module tb_bus_command_controller;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // Vector layout: {ALE, DT/R#, DEN, active, MRDC#, MWTC#, IORC#, IOWC#, INTA#}
  logic [8:0] sb [$];
  logic [2:0] codes [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  localparam logic [8:0] IDLE_VEC = 9'b0_1_0_0_11111;

  bus_command_controller_if bus ();

  bus_command_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] vec(logic ale, logic dtr, logic den, logic act, logic [4:0] stb);
    return {ale, dtr, den, act, stb};
  endfunction

  function automatic logic [4:0] expectedStrobe(logic [2:0] st);
    case (st)
      3'b000:  return 5'b11110;
      3'b001:  return 5'b11011;
      3'b010:  return 5'b11101;
      3'b100:  return 5'b01111;
      3'b101:  return 5'b01111;
      3'b110:  return 5'b10111;
      default: return 5'b11111;
    endcase
  endfunction

  task automatic checkOutput(input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {bus.address_latch_enable, bus.data_transmit_receive_n, bus.data_enable,
           bus.bus_cycle_active, bus.memory_read_n, bus.memory_write_n,
           bus.io_read_n, bus.io_write_n, bus.interrupt_acknowledge_n};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, observed=%b", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic rdy, input logic aen,
                               input logic rst, input string tag);
    bus.processor_status = st;
    bus.processor_ready  = rdy;
    bus.address_enable   = aen;
    reset                = rst;
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleStep(input logic [2:0] st, input string tag);
    sb.push_back(IDLE_VEC);
    applyStimulus(st, 1'b1, 1'b0, 1'b0, tag);
  endtask

  // Runs one bus cycle from the sampling edge up to and including entry into T4.
  task automatic runCycle(input logic [2:0] st, input int waits,
                          input logic aenEarly, input logic aenLate);
    logic       d;
    logic [4:0] s;
    logic [2:0] junk;
    d    = (st == 3'b010) || (st == 3'b110);
    s    = expectedStrobe(st);
    junk = st ^ 3'b011;
    sb.push_back(vec(1'b1, d, 1'b0, 1'b1, 5'b11111));
    applyStimulus(st, 1'b1, aenEarly, 1'b0, $sformatf("T1 st=%b", st));
    sb.push_back(vec(1'b0, d, 1'b1, 1'b1, aenEarly ? 5'b11111 : s));
    applyStimulus(junk, 1'b1, aenEarly, 1'b0, $sformatf("T2 st=%b", st));
    sb.push_back(vec(1'b0, d, 1'b1, 1'b1, aenLate ? 5'b11111 : s));
    applyStimulus(junk, 1'b1, aenLate, 1'b0, $sformatf("T3 st=%b", st));
    for (int i = 0; i < waits; i++) begin
      sb.push_back(vec(1'b0, d, 1'b1, 1'b1, aenLate ? 5'b11111 : s));
      applyStimulus(junk, 1'b0, aenLate, 1'b0, $sformatf("TW%0d st=%b", i, st));
    end
    sb.push_back(vec(1'b0, d, 1'b1, 1'b1, 5'b11111));
    applyStimulus(junk, 1'b1, aenLate, 1'b0, $sformatf("T4 st=%b", st));
  endtask

  initial begin
    bus.processor_status = 3'b111;
    bus.processor_ready  = 1'b1;
    bus.address_enable   = 1'b0;
    reset                = 1'b1;

    sb.push_back(IDLE_VEC);
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b1, "reset0");
    sb.push_back(IDLE_VEC);
    applyStimulus(3'b101, 1'b1, 1'b0, 1'b1, "reset1");
    idleStep(3'b111, "post-reset idle");

    $display("[TB] memory read, no waits");
    runCycle(3'b101, 0, 1'b0, 1'b0);
    idleStep(3'b111, "after mem read");

    $display("[TB] IO write, three wait states");
    runCycle(3'b010, 3, 1'b0, 1'b0);
    idleStep(3'b111, "after io write");

    $display("[TB] IO read under DMA ownership");
    runCycle(3'b001, 0, 1'b1, 1'b1);
    idleStep(3'b111, "after masked io read");

    $display("[TB] DMA released mid-cycle");
    runCycle(3'b001, 1, 1'b1, 1'b0);
    idleStep(3'b111, "after mask release");

    $display("[TB] back-to-back fetch then memory write");
    runCycle(3'b100, 0, 1'b0, 1'b0);
    runCycle(3'b110, 0, 1'b0, 1'b0);
    idleStep(3'b111, "after back-to-back");

    $display("[TB] halt then interrupt acknowledge");
    idleStep(3'b011, "enter halt");
    idleStep(3'b101, "halt ignores command");
    idleStep(3'b111, "halt exit");
    runCycle(3'b000, 0, 1'b0, 1'b0);
    idleStep(3'b111, "after inta");

    $display("[TB] reset during wait state of memory write");
    sb.push_back(vec(1'b1, 1'b1, 1'b0, 1'b1, 5'b11111));
    applyStimulus(3'b110, 1'b1, 1'b0, 1'b0, "wr T1");
    sb.push_back(vec(1'b0, 1'b1, 1'b1, 1'b1, 5'b10111));
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, "wr T2");
    sb.push_back(vec(1'b0, 1'b1, 1'b1, 1'b1, 5'b10111));
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, "wr T3");
    sb.push_back(vec(1'b0, 1'b1, 1'b1, 1'b1, 5'b10111));
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, "wr TW");
    sb.push_back(IDLE_VEC);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, "reset in TW");
    runCycle(3'b101, 0, 1'b0, 1'b0);
    idleStep(3'b111, "after post-reset read");

    $display("[TB] mixed cycle types with random waits");
    for (int i = 0; i < 6; i++) begin
      runCycle(codes[i], int'($urandom_range(0, 2)), 1'b0, 1'b0);
      if (i % 2 == 1) idleStep(3'b111, "mixed idle");
    end
    idleStep(3'b111, "final idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
